// File: rtl/dsp_preadd_mac.sv
// Pipelined pre-add/pre-subtract multiply-accumulate slice: P = ((D op B) * A) + C, 4-cycle latency.
// Optional clock enable input ce is built when DSP_CE_EN is defined.
module dsp_preadd_mac #(
    parameter string OPERATION = "ADD"
) (
    input  logic        clk,
    input  logic        rst,
`ifdef DSP_CE_EN
    input  logic        ce,
`endif
    input  logic [17:0] A,
    input  logic [17:0] B,
    input  logic [17:0] D,
    input  logic [47:0] C,
    output logic [47:0] P
);

    // Any value other than "SUBTRACT" selects the pre-adder.
    localparam bit IS_SUB = (OPERATION == "SUBTRACT");

    logic        en;
`ifdef DSP_CE_EN
    assign en = ce;
`else
    assign en = 1'b1;
`endif

    // Stage 1 registers
    logic [17:0] a1, b1, d1;
    logic [47:0] c1;
    // Stage 2 registers
    logic [18:0] pre;
    logic [17:0] a2;
    logic [47:0] c2;
    // Stage 3 registers
    logic [36:0] m;
    logic [47:0] c3;

    logic [18:0]        pre_next;
    logic [36:0]        prod_u;
    logic signed [36:0] prod_s;
    logic [36:0]        m_next;
    logic [47:0]        m_ext;
    logic [47:0]        p_next;

    always_comb begin
        pre_next = '0;
        if (IS_SUB) begin
            pre_next = {1'b0, d1} - {1'b0, b1};
        end else begin
            pre_next = {1'b0, d1} + {1'b0, b1};
        end
    end

    // |PRE| < 2^18 and A < 2^18, so the signed product always fits in 37 bits.
    always_comb begin
        prod_u = pre * a2;
        prod_s = $signed(pre) * $signed({1'b0, a2});
        m_next = IS_SUB ? prod_s : prod_u;
    end

    always_comb begin
        m_ext  = IS_SUB ? {{11{m[36]}}, m} : {11'b0, m};
        p_next = m_ext + c3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a1  <= '0;
            b1  <= '0;
            d1  <= '0;
            c1  <= '0;
            pre <= '0;
            a2  <= '0;
            c2  <= '0;
            m   <= '0;
            c3  <= '0;
            P   <= '0;
        end else if (en) begin
            a1  <= A;
            b1  <= B;
            d1  <= D;
            c1  <= C;
            pre <= pre_next;
            a2  <= a1;
            c2  <= c1;
            m   <= m_next;
            c3  <= c2;
            P   <= p_next;
        end
    end

endmodule

// File: tb/tb_dsp_preadd_mac.sv
// Bench for dsp_preadd_mac: one ADD and one SUBTRACT instance driven with identical operands.
module tb_dsp_preadd_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [17:0] a, b, d;
    logic [47:0] c;
    logic [47:0] p_add, p_sub;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    dsp_preadd_mac #(.OPERATION("ADD")) dut_add (
        .clk(clk),
        .rst(rst),
`ifdef DSP_CE_EN
        .ce (ce),
`endif
        .A  (a),
        .B  (b),
        .D  (d),
        .C  (c),
        .P  (p_add)
    );

    dsp_preadd_mac #(.OPERATION("SUBTRACT")) dut_sub (
        .clk(clk),
        .rst(rst),
`ifdef DSP_CE_EN
        .ce (ce),
`endif
        .A  (a),
        .B  (b),
        .D  (d),
        .C  (c),
        .P  (p_sub)
    );

    typedef struct {
        logic        rst;
        logic [17:0] a, b, d;
        logic [47:0] c;
        logic [47:0] exp_add, exp_sub;
    } vec_t;

    vec_t vecs[$];

    // Reference model: result of each accepted operand set, released three enabled edges later.
    logic [47:0] qa[$], qs[$];
    logic [47:0] exp_a, exp_s;

    function automatic logic [47:0] ref_p(bit sub, logic [17:0] fa, logic [17:0] fb,
                                          logic [17:0] fd, logic [47:0] fc);
        longint pre, r;
        pre = sub ? (longint'(fd) - longint'(fb)) : (longint'(fd) + longint'(fb));
        r   = pre * longint'(fa) + longint'(fc);
        return r[47:0];
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%012h expected 0x%012h", name, act, exp);
        end
    endtask

    // Drive one clock of operands (called at negedge), advance the model, sample at next negedge.
    task automatic cycle(input logic r, input logic e, input logic [17:0] ia, input logic [17:0] ib,
                         input logic [17:0] id, input logic [47:0] ic);
        rst = r; ce = e; a = ia; b = ib; d = id; c = ic;
        @(posedge clk);
        @(negedge clk);
`ifndef DSP_CE_EN
        e = 1'b1;
`endif
        if (r) begin
            qa = '{48'd0, 48'd0, 48'd0};
            qs = '{48'd0, 48'd0, 48'd0};
            exp_a = '0;
            exp_s = '0;
        end else if (e) begin
            qa.push_back(ref_p(1'b0, ia, ib, id, ic));
            qs.push_back(ref_p(1'b1, ia, ib, id, ic));
            exp_a = qa.pop_front();
            exp_s = qs.pop_front();
        end
    endtask

    task automatic rand_cycle(input string tag, input logic r, input logic e);
        logic [47:0] rc;
        rc = {$urandom(), $urandom()};
        cycle(r, e, 18'($urandom()), 18'($urandom()), 18'($urandom()), rc);
        chk({tag, "_add"}, p_add, exp_a);
        chk({tag, "_sub"}, p_sub, exp_s);
    endtask

    localparam logic [47:0] T2A = 48'd27;
    localparam logic [47:0] T2S = 48'hFFFF_FFFF_FFF3;   // (3-10)*2+1
    localparam logic [47:0] T3A = 48'h001F_FFF0_0001;
    localparam logic [47:0] T3S = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] T5A1 = 48'd126, T5S1 = 48'd86;
    localparam logic [47:0] T5A2 = 48'd5,   T5S2 = 48'hFFFF_FFFF_FFFB;

    task automatic add_vec(input logic r, input logic [17:0] va, input logic [17:0] vb,
                           input logic [17:0] vd, input logic [47:0] vc,
                           input logic [47:0] ea, input logic [47:0] es);
        vec_t v;
        v.rst = r; v.a = va; v.b = vb; v.d = vd; v.c = vc; v.exp_add = ea; v.exp_sub = es;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; a = '0; b = '0; d = '0; c = '0;
        exp_a = '0; exp_s = '0;

        for (int unsigned i = 0; i < 5; i++) add_vec(1'b1, 18'd2, 18'd10, 18'd3, 48'd1, 48'd0, 48'd0);
        for (int unsigned i = 0; i < 3; i++) add_vec(1'b0, 18'd2, 18'd10, 18'd3, 48'd1, 48'd0, 48'd0);
        for (int unsigned i = 0; i < 3; i++) add_vec(1'b0, 18'd2, 18'd10, 18'd3, 48'd1, T2A, T2S);
        for (int unsigned i = 0; i < 3; i++)
            add_vec(1'b0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, T2A, T2S);
        add_vec(1'b0, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, T3A, T3S);
        add_vec(1'b0, 18'd2, 18'd10, 18'd3, 48'd100, T3A, T3S);
        add_vec(1'b0, 18'd1, 18'd5, 18'd0, 48'd0, T3A, T3S);
        add_vec(1'b0, 18'd1, 18'd5, 18'd0, 48'd0, T3A, T3S);
        add_vec(1'b0, 18'd1, 18'd5, 18'd0, 48'd0, T5A1, T5S1);
        add_vec(1'b0, 18'd1, 18'd5, 18'd0, 48'd0, T5A2, T5S2);

        @(negedge clk);
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, 1'b1, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].c);
            chk($sformatf("vec%0d_add", i), p_add, vecs[i].exp_add);
            chk($sformatf("vec%0d_sub", i), p_sub, vecs[i].exp_sub);
        end

        // Random back-to-back stream
        for (int unsigned i = 0; i < 15; i++) rand_cycle("stream", 1'b0, 1'b1);

        // Mid-stream reset: in-flight sets must be flushed
        rand_cycle("midrst", 1'b1, 1'b1);
        chk("midrst_zero", p_add, 48'd0);
        for (int unsigned i = 0; i < 3; i++) begin
            rand_cycle("postrst", 1'b0, 1'b1);
            chk("postrst_zero", p_add | p_sub, 48'd0);
        end
        for (int unsigned i = 0; i < 6; i++) rand_cycle("resume", 1'b0, 1'b1);

`ifdef DSP_CE_EN
        for (int unsigned i = 0; i < 3; i++) rand_cycle("ce_hold", 1'b0, 1'b0);
        for (int unsigned i = 0; i < 6; i++) rand_cycle("ce_resume", 1'b0, 1'b1);
        rand_cycle("ce_rst", 1'b1, 1'b0);
        chk("ce_rst_zero", p_add, 48'd0);
        for (int unsigned i = 0; i < 6; i++) rand_cycle("ce_mix", 1'b0, 1'($urandom()));
`endif

        for (int unsigned i = 0; i < 20; i++) rand_cycle("tail", 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
